seq_fsm_pattern2_gen: RTL and testbench

Serial pattern transmitter that drives the "three-or-more ones followed by a zero" pattern. This is the pattern recognised by the team's Moore pattern-2 detector FSM. On an accepted request it emits N ones then one zero, optionally repeated back-to-back. The block provides stimulus for the detector in loopback benches and sits in front of any serial consumer of that pattern.

---
 rtl/seq_fsm_pattern2_gen.sv | 116 +++++++++++
 tb/tb_seq_fsm_pattern2_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_fsm_pattern2_gen.sv
// ---------------------------------------------------------------------------
// seq_fsm_pattern2_gen
//
// Serial transmitter for the "three-or-more ones followed by a zero" pattern.
// An accepted request emits n ones then a single zero (one frame), repeated
// r times with no gap between frames. The outputs are Moore outputs: they are
// decoded from the registered state and counters only.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   req_val    request valid
//   req_rdy    request ready, high only in IDLE
//   req_nones  ones per frame (0..2 are raised to 3)
//   req_reps   frames per request (0 is treated as 1)
//   out_       serial bit to the pattern consumer
//   out_val    high while a frame bit is driven
//   done       one-cycle pulse on the final zero of the final frame
// ---------------------------------------------------------------------------
module seq_fsm_pattern2_gen #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_nones,
    input  logic [NBITS-1:0] req_reps,
    output logic             out_,
    output logic             out_val,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        ZERO = 2'd2
    } state_t;

    localparam logic [NBITS-1:0] MIN_ONES = NBITS'(3);
    localparam logic [NBITS-1:0] ONE      = NBITS'(1);

    state_t           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;     // ones left in the current frame
    logic [NBITS-1:0] n_q, n_d;         // latched ones per frame
    logic [NBITS-1:0] r_q, r_d;         // frames left, including the current one

    logic [NBITS-1:0] nones_clamped;
    logic [NBITS-1:0] reps_clamped;

    assign nones_clamped = (req_nones < MIN_ONES) ? MIN_ONES : req_nones;
    assign reps_clamped  = (req_reps == '0) ? ONE : req_reps;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        r_d     = r_q;
        req_rdy = 1'b0;
        out_    = 1'b0;
        out_val = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    n_d     = nones_clamped;
                    r_d     = reps_clamped;
                    cnt_d   = nones_clamped;
                    state_d = ONES;
                end
            end
            ONES: begin
                out_    = 1'b1;
                out_val = 1'b1;
                cnt_d   = cnt_q - ONE;
                // The counter counts down to 1 rather than 0, so a count of
                // 2^NBITS-1 still fits and is sent in full.
                if (cnt_q == ONE) begin
                    state_d = ZERO;
                end
            end
            ZERO: begin
                out_val = 1'b1;
                if (r_q > ONE) begin
                    r_d     = r_q - ONE;
                    cnt_d   = n_q;
                    state_d = ONES;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                // Unused encoding: fall back to IDLE on the next edge.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            r_q     <= r_d;
        end
    end

endmodule

// File: tb/tb_seq_fsm_pattern2_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_fsm_pattern2_gen
//
// Directed bench for seq_fsm_pattern2_gen. Each request pushes the expected
// per-cycle output vector {out_, out_val, done, req_rdy} onto a queue; every
// cycle one entry is popped and compared against the DUT outputs. A small
// Moore pattern detector in the bench watches out_ for the loopback scenario.
// ---------------------------------------------------------------------------
module tb_seq_fsm_pattern2_gen;

    localparam int NBITS = 4;

    logic             clk;
    logic             reset;
    logic             req_val;
    logic             req_rdy;
    logic [NBITS-1:0] req_nones;
    logic [NBITS-1:0] req_reps;
    logic             out_;
    logic             out_val;
    logic             done;

    seq_fsm_pattern2_gen #(.NBITS(NBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_nones (req_nones),
        .req_reps  (req_reps),
        .out_      (out_),
        .out_val   (out_val),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {out_, out_val, done, req_rdy}
    logic [3:0] exp_q[$];
    int         n_compared = 0;
    int         n_mismatch = 0;
    int         cycle_no   = 0;
    string      cur_tag    = "init";

    // Loopback bookkeeping
    int         val_cycles  = 0;
    int         det_pulses  = 0;
    logic       prev_zero   = 1'b0;

    // Reference Moore detector: states 0..3 count ones (saturating at 3),
    // state 4 means "3+ ones then a zero" and drives the detector output.
    int         det_state;
    logic       det_out;
    assign det_out = (det_state == 4);

    always @(posedge clk) begin
        if (!reset) begin
            det_state <= 0;
        end else if (out_) begin
            det_state <= (det_state >= 3 && det_state != 4) ? 3 : ((det_state == 4) ? 1 : det_state + 1);
        end else begin
            det_state <= (det_state == 3) ? 4 : 0;
        end
    end

    function automatic int clamp_n(input int v);
        return (v < 3) ? 3 : v;
    endfunction

    function automatic int clamp_r(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic push_idle();
        exp_q.push_back(4'b0001);
    endtask

    task automatic push_txn(input int nones, input int reps);
        int n;
        int r;
        n = clamp_n(nones);
        r = clamp_r(reps);
        for (int f = 0; f < r; f++) begin
            for (int i = 0; i < n; i++) exp_q.push_back(4'b1100);
            exp_q.push_back({1'b0, 1'b1, (f == r - 1), 1'b0});
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, compare one entry.
    task automatic step();
        logic [3:0] e;
        logic [3:0] a;
        @(posedge clk);
        #1;
        cycle_no++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0001;
        a = {out_, out_val, done, req_rdy};
        n_compared++;
        assert (a === e) else begin
            n_mismatch++;
            $error("FAIL %s cycle %0d: {out_,out_val,done,req_rdy} observed %b expected %b",
                   cur_tag, cycle_no, a, e);
        end
        $display("[%0d] %s out_=%b out_val=%b done=%b req_rdy=%b exp=%b",
                 cycle_no, cur_tag, out_, out_val, done, req_rdy, e);
        if (out_val) val_cycles++;
        if (det_out) begin
            det_pulses++;
            n_compared++;
            assert (prev_zero === 1'b1) else begin
                n_mismatch++;
                $error("FAIL %s det_align cycle %0d: previous-cycle zero observed %b expected 1",
                       cur_tag, cycle_no, prev_zero);
            end
        end
        prev_zero = out_val && !out_;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic send(input int nones, input int reps);
        req_val   = 1'b1;
        req_nones = NBITS'(nones);
        req_reps  = NBITS'(reps);
        push_txn(nones, reps);
        step();                 // accept edge; first '1' visible here
        req_val   = 1'b0;
        req_nones = '0;
        req_reps  = '0;
        drain();
        push_idle();
        step();
    endtask

    initial begin
        reset     = 1'b0;
        req_val   = 1'b0;
        req_nones = '0;
        req_reps  = '0;

        // Reset state
        cur_tag = "reset";
        repeat (2) @(posedge clk);
        push_idle();
        step();
        reset = 1'b1;
        push_idle();
        step();

        cur_tag = "n3_r1";
        send(3, 1);

        cur_tag = "n0_r0_clamp";
        send(0, 0);

        cur_tag = "n5_r2";
        send(5, 2);

        // Continuous req_val: second accept on the single idle edge
        cur_tag = "hold_val";
        req_val   = 1'b1;
        req_nones = NBITS'(3);
        req_reps  = NBITS'(1);
        push_txn(3, 1);
        push_idle();
        push_txn(3, 1);
        push_idle();
        repeat (6) step();      // 4 busy + idle + first one of frame 2
        req_val = 1'b0;
        drain();

        // Reset on the 2nd ONES cycle of a nones=4 frame
        cur_tag = "reset_mid";
        req_val   = 1'b1;
        req_nones = NBITS'(4);
        req_reps  = NBITS'(1);
        exp_q.push_back(4'b1100);
        step();                 // 1st ONES cycle
        req_val = 1'b0;
        exp_q.push_back(4'b1100);
        step();                 // 2nd ONES cycle
        reset = 1'b0;
        push_idle();
        step();
        reset = 1'b1;
        repeat (4) push_idle();
        drain();

        cur_tag = "after_reset";
        send(4, 1);

        // Loopback with the maximum field values
        cur_tag    = "loop_15x15";
        val_cycles = 0;
        det_pulses = 0;
        send(15, 15);
        n_compared++;
        assert (val_cycles === 240) else begin
            n_mismatch++;
            $error("FAIL loop_valcycles: observed %0d expected 240", val_cycles);
        end
        n_compared++;
        assert (det_pulses === 15) else begin
            n_mismatch++;
            $error("FAIL loop_detpulses: observed %0d expected 15", det_pulses);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
